instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder.
- Holds the PC and sequences each fetch: MAR load, RAM read with MFC handshake, MDR capture, IR load.
- Presents the 32-bit IR contents to the decoder, then waits for the datapath to finish execution before fetching the next word.
- Handles sequential PC advance, taken branches, and a memory-wait watchdog.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/fetch_watchdog.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 97 +++++++++
 tb/tb_instruction_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Covers the fetch FSM state encoding, the PC step and default parameter values.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_MAR,
      MEM_WAIT,
      LOAD_IR,
      EXEC,
      FAULT
   } fetch_state_e;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_TIMEOUT  = 15;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side and decoder/datapath-side signals of the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_unit_if;
   logic        mar_en;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mfc;
   logic [31:0] mem_rdata;
   logic        mdr_en;
   logic        ir_en;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        exec_done;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic        fetch_fault;

   modport master (
      output mar_en, mem_addr, mem_rd, mdr_en, ir_en, instruction, instr_valid, pc, fetch_fault,
      input  mfc, mem_rdata, exec_done, branch_taken, branch_target
   );

   modport slave (
      input  mar_en, mem_addr, mem_rd, mdr_en, ir_en, instruction, instr_valid, pc, fetch_fault,
      output mfc, mem_rdata, exec_done, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_watchdog.sv
// 8-bit memory-wait counter; expired flags the cycle on which an unanswered
// read would bring the count up to TIMEOUT.
module fetch_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [7:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 8'd0;
      end else if (clear) begin
         count_q <= 8'd0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         count_q <= count_q + 8'd1;
      end
   end

   assign expired = en && ((count_q + 8'd1) == 8'(TIMEOUT));

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC/MAR/MDR/IR registers and the fetch sequencer feeding the instruction decoder.
// Fetches one word, holds it valid until exec_done, then fetches the next.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
   input  logic                            clk,
   input  logic                            reset_n,
   instruction_fetch_unit_if.master        bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, mar_q, mdr_q, ir_q;
   logic         wd_clear, wd_en, wd_expired;

   fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (wd_clear),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d          = state_q;
      bus.mar_en       = 1'b0;
      bus.mem_rd       = 1'b0;
      bus.mdr_en       = 1'b0;
      bus.ir_en        = 1'b0;
      bus.instr_valid  = 1'b0;
      bus.fetch_fault  = 1'b0;
      wd_clear         = 1'b0;
      wd_en            = 1'b0;
      case (state_q)
         IDLE:     state_d = LOAD_MAR;
         LOAD_MAR: begin
            bus.mar_en = 1'b1;
            wd_clear   = 1'b1;
            state_d    = MEM_WAIT;
         end
         MEM_WAIT: begin
            bus.mem_rd = 1'b1;
            if (bus.mfc) begin
               bus.mdr_en = 1'b1;
               state_d    = LOAD_IR;
            end else begin
               wd_en = 1'b1;
               if (wd_expired) state_d = FAULT;
            end
         end
         LOAD_IR: begin
            bus.ir_en = 1'b1;
            state_d   = EXEC;
         end
         EXEC: begin
            bus.instr_valid = 1'b1;
            if (bus.exec_done) state_d = LOAD_MAR;
         end
         FAULT:    bus.fetch_fault = 1'b1;
         default:  state_d = IDLE;
      endcase
   end

   // Registers load only in their own state, so FAULT freezes everything, pc included.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q  <= RESET_PC;
         mar_q <= 32'd0;
         mdr_q <= 32'd0;
         ir_q  <= 32'd0;
      end else begin
         case (state_q)
            LOAD_MAR: mar_q <= pc_q;
            MEM_WAIT: if (bus.mfc) mdr_q <= bus.mem_rdata;
            LOAD_IR: begin
               ir_q <= mdr_q;
               pc_q <= pc_q + PC_INCR;
            end
            EXEC:     if (bus.exec_done && bus.branch_taken) pc_q <= bus.branch_target & ~32'h3;
            default:  ;
         endcase
      end
   end

   assign bus.mem_addr    = mar_q;
   assign bus.instruction = ir_q;
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit, checked against a
// transaction-level PC/instruction model kept here.
module tb_instruction_fetch_unit;

   localparam int          TO  = 15;
   localparam logic [31:0] RST = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(.RESET_PC(RST), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic wait_mar();
      int n = 0;
      while (bus.mar_en !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check_bit("mar_en_reached", bus.mar_en, 1'b1);
   endtask

   // One full fetch/execute; starts anywhere before LOAD_MAR, ends at the next LOAD_MAR.
   task automatic fetch(input logic [31:0] data, input int mfc_delay, input int exec_delay,
                        input logic taken, input logic [31:0] target);
      int rd_cycles = 0;
      wait_mar();
      @(negedge clk);
      check("mem_addr", bus.mem_addr, exp_pc);
      for (int i = 0; i <= mfc_delay; i++) begin
         bus.mfc       = (i == mfc_delay);
         bus.mem_rdata = (i == mfc_delay) ? data : $urandom();
         #1;
         if (bus.mem_rd === 1'b1) rd_cycles++;
         check_bit("mdr_en", bus.mdr_en, i == mfc_delay);
         @(negedge clk);
      end
      bus.mfc       = 1'b0;
      bus.mem_rdata = $urandom();
      check("mem_rd_cycles", rd_cycles, mfc_delay + 1);
      check_bit("ir_en", bus.ir_en, 1'b1);
      check_bit("mem_rd_after_mfc", bus.mem_rd, 1'b0);
      @(negedge clk);
      check_bit("instr_valid", bus.instr_valid, 1'b1);
      check("instruction", bus.instruction, data);
      check("pc_incr", bus.pc, exp_pc + 32'd4);
      check_bit("no_fault", bus.fetch_fault, 1'b0);
      exp_pc = exp_pc + 32'd4;
      for (int i = 0; i < exec_delay; i++) begin
         bus.branch_taken  = 1'($urandom_range(0, 1));
         bus.branch_target = $urandom();
         bus.mfc           = 1'($urandom_range(0, 1));
         #1;
         check_bit("mdr_en_exec", bus.mdr_en, 1'b0);
         @(negedge clk);
         check("instr_hold", bus.instruction, data);
         check("pc_hold", bus.pc, exp_pc);
      end
      bus.mfc           = 1'b0;
      bus.exec_done     = 1'b1;
      bus.branch_taken  = taken;
      bus.branch_target = target;
      @(negedge clk);
      bus.exec_done    = 1'b0;
      bus.branch_taken = 1'b0;
      if (taken) exp_pc = target & ~32'h3;
      check("pc_after_exec", bus.pc, exp_pc);
      check_bit("mar_en_next", bus.mar_en, 1'b1);
      check_bit("instr_valid_drop", bus.instr_valid, 1'b0);
   endtask

   initial begin
      int n;
      bus.mfc           = 1'b0;
      bus.mem_rdata     = 32'd0;
      bus.exec_done     = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'd0;
      reset_n           = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_pc", bus.pc, RST);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_instruction", bus.instruction, 32'd0);
      check_bit("rst_mar_en", bus.mar_en, 1'b0);
      check_bit("rst_mdr_en", bus.mdr_en, 1'b0);
      check_bit("rst_ir_en", bus.ir_en, 1'b0);
      check_bit("rst_mem_rd", bus.mem_rd, 1'b0);
      check_bit("rst_instr_valid", bus.instr_valid, 1'b0);
      check_bit("rst_fetch_fault", bus.fetch_fault, 1'b0);

      reset_n = 1'b1;
      exp_pc  = RST;

      // Directed fetches: minimum latency, delayed mfc with branch, PC wrap.
      fetch(32'hE281_1001, 0, 2, 1'b0, 32'd0);
      fetch($urandom(), 5, 1, 1'b1, 32'h0000_0103);
      check("branch_pc", exp_pc, 32'h0000_0100);
      fetch($urandom(), 1, 0, 1'b1, 32'hFFFF_FFFE);
      fetch($urandom(), 0, 1, 1'b0, 32'd0);
      check("wrap_pc", bus.pc, 32'd0);

      repeat (20)
         fetch($urandom(), $urandom_range(0, TO - 1), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom());

      // Reset in the middle of a memory wait.
      wait_mar();
      @(negedge clk);
      check_bit("mid_wait_mem_rd", bus.mem_rd, 1'b1);
      reset_n = 1'b0;
      #1;
      check_bit("async_rst_mem_rd", bus.mem_rd, 1'b0);
      check_bit("async_rst_instr_valid", bus.instr_valid, 1'b0);
      check_bit("async_rst_fault", bus.fetch_fault, 1'b0);
      check("async_rst_pc", bus.pc, RST);
      @(negedge clk);
      reset_n = 1'b1;
      exp_pc  = RST;
      fetch($urandom(), 2, 0, 1'b0, 32'd0);

      // Watchdog: mfc never arrives.
      wait_mar();
      @(negedge clk);
      n = 0;
      while (bus.mem_rd === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("wait_cycles_to_fault", n, TO);
      check_bit("fault_set", bus.fetch_fault, 1'b1);
      check_bit("fault_mem_rd", bus.mem_rd, 1'b0);
      check("fault_pc", bus.pc, exp_pc);
      repeat (4) begin
         bus.mfc           = 1'b1;
         bus.exec_done     = 1'b1;
         bus.branch_taken  = 1'b1;
         bus.branch_target = $urandom();
         bus.mem_rdata     = $urandom();
         @(negedge clk);
         check_bit("fault_sticky", bus.fetch_fault, 1'b1);
         check_bit("fault_mem_rd_low", bus.mem_rd, 1'b0);
         check_bit("fault_mar_en", bus.mar_en, 1'b0);
         check_bit("fault_mdr_en", bus.mdr_en, 1'b0);
         check_bit("fault_ir_en", bus.ir_en, 1'b0);
         check_bit("fault_instr_valid", bus.instr_valid, 1'b0);
         check("fault_pc_frozen", bus.pc, exp_pc);
      end
      bus.mfc          = 1'b0;
      bus.exec_done    = 1'b0;
      bus.branch_taken = 1'b0;
      reset_n          = 1'b0;
      #1;
      check_bit("fault_cleared", bus.fetch_fault, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_pc  = RST;
      fetch($urandom(), 0, 0, 1'b0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
